// File: rtl/fft_peak_detect_if.sv
// Bin stream from the FFT output sequencer and the per-frame peak result
// returned to the note-lookup logic.
interface fft_peak_detect_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 9
);
  logic                     reset_max;
  logic                     bin_valid;
  logic [IDX_W-1:0]         bin_index;
  logic signed [DATA_W-1:0] bin_re;
  logic signed [DATA_W-1:0] bin_im;
  logic                     peak_valid;
  logic [IDX_W-1:0]         peak_bin;
  logic [2*DATA_W:0]        peak_mag;
  logic                     note_on;
  logic                     busy;

  modport master (
    output reset_max, bin_valid, bin_index, bin_re, bin_im,
    input  peak_valid, peak_bin, peak_mag, note_on, busy
  );

  modport slave (
    input  reset_max, bin_valid, bin_index, bin_re, bin_im,
    output peak_valid, peak_bin, peak_mag, note_on, busy
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Per-frame FFT peak search: 3-stage magnitude pipeline and windowed running max.
// Define PEAK_SQUARED_MAG_EN for re^2+im^2 magnitudes; default is the |re|+|im| estimate.
module fft_peak_detect #(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 9,
  parameter int MIN_BIN = 1,
  parameter int MAX_BIN = 255,
  parameter int THRESH  = 1000
) (
  input logic             clk,
  input logic             reset,
  fft_peak_detect_if.slave bus
);

  localparam int MAG_W  = 2*DATA_W + 1;
  localparam int STAGES = 3;

  localparam logic [IDX_W-1:0] LAST_IDX   = '1;
  localparam logic [IDX_W-1:0] MIN_IDX    = IDX_W'(MIN_BIN);
  localparam logic [IDX_W-1:0] MAX_IDX    = IDX_W'(MAX_BIN);
  localparam logic [MAG_W-1:0] THRESH_MAG = MAG_W'(THRESH);
  localparam logic [1:0]       FLUSH_LAST = 2'(STAGES-1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  // Sign-extend first so the most negative input maps to +2^(DATA_W-1).
  function automatic logic [DATA_W:0] abs_val(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] ext;
    ext = (DATA_W+1)'(x);
    if (ext < 0) abs_val = $unsigned(-ext);
    else         abs_val = $unsigned(ext);
  endfunction

  function automatic logic [MAG_W-1:0] mag_of(input logic [DATA_W:0] a,
                                              input logic [DATA_W:0] b);
    logic [MAG_W-1:0] ea;
    logic [MAG_W-1:0] eb;
    ea = MAG_W'(a);
    eb = MAG_W'(b);
`ifdef PEAK_SQUARED_MAG_EN
    mag_of = (ea * ea) + (eb * eb);
`else
    mag_of = ea + eb;
`endif
  endfunction

  logic [1:0]       state;
  logic [1:0]       flush_cnt;

  logic             vld_p0;
  logic [DATA_W:0]  abs_re_p0;
  logic [DATA_W:0]  abs_im_p0;
  logic [IDX_W-1:0] idx_p0;

  logic             vld_p1;
  logic [MAG_W-1:0] mag_p1;
  logic [IDX_W-1:0] idx_p1;

  logic [MAG_W-1:0] max_mag;
  logic [IDX_W-1:0] max_bin;

  logic             peak_valid_q;
  logic [IDX_W-1:0] peak_bin_q;
  logic [MAG_W-1:0] peak_mag_q;
  logic             note_on_q;

  logic             idx_zero;
  logic             frame_start;
  logic             accept;
  logic             in_window;
  logic             update;

  assign idx_zero    = (bus.bin_index == '0);
  assign frame_start = bus.bin_valid && idx_zero &&
                       ((state == S_IDLE) || (state == S_ACCUM));
  assign accept      = !bus.reset_max && bus.bin_valid &&
                       ((state == S_ACCUM) || ((state == S_IDLE) && idx_zero));
  assign in_window   = (idx_p1 >= MIN_IDX) && (idx_p1 <= MAX_IDX);
  assign update      = vld_p1 && in_window && (mag_p1 > max_mag);

  // S1: absolute values of the accepted bin
  always_ff @(posedge clk) begin
    if (accept) begin
      abs_re_p0 <= abs_val(bus.bin_re);
      abs_im_p0 <= abs_val(bus.bin_im);
      idx_p0    <= bus.bin_index;
    end
  end

  // S2: magnitude
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      mag_p1 <= mag_of(abs_re_p0, abs_im_p0);
      idx_p1 <= idx_p0;
    end
  end

  // S3: running max, frame sequencing and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      flush_cnt    <= '0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      max_mag      <= '0;
      max_bin      <= '0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      note_on_q    <= 1'b0;
    end else if (bus.reset_max) begin
      state        <= S_IDLE;
      flush_cnt    <= '0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      max_mag      <= '0;
      max_bin      <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= 1'b0;
      vld_p0       <= accept;
      // A restart discards the bin already in S2 along with the old max.
      vld_p1       <= vld_p0 && !frame_start;

      if (frame_start) begin
        max_mag <= '0;
        max_bin <= '0;
      end else if (update) begin
        max_mag <= mag_p1;
        max_bin <= idx_p1;
      end

      case (state)
        S_IDLE: begin
          if (frame_start) state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (accept && (bus.bin_index == LAST_IDX)) begin
            state     <= S_FLUSH;
            flush_cnt <= '0;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state        <= S_REPORT;
            peak_valid_q <= 1'b1;
            peak_bin_q   <= max_bin;
            peak_mag_q   <= max_mag;
            note_on_q    <= (max_mag >= THRESH_MAG);
          end else begin
            flush_cnt <= flush_cnt + 2'd1;
          end
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_bin   = peak_bin_q;
  assign bus.peak_mag   = peak_mag_q;
  assign bus.note_on    = note_on_q;
  assign bus.busy       = (state == S_ACCUM) || (state == S_FLUSH);

endmodule

// File: doc/fft_peak_detect.md
# fft_peak_detect

Downstream consumer of the FFT output phase. It takes one complex FFT bin per valid cycle while the sequencer sweeps `output_index` and computes each bin's magnitude in a 3-stage pipeline. It tracks the largest magnitude inside a configurable bin window and reports the winning bin, its magnitude and a threshold flag once per frame. The sequencer's `reset_max` clears the running search; the note-lookup logic downstream reads the reported result.

## Interface
- `DATA_W`, 16: signed width of `bin_re` / `bin_im`.
- `IDX_W`, 9: bin index width; frame length is 2^IDX_W.
- `MIN_BIN`, 1: lowest bin searched (inclusive); excludes DC.
- `MAX_BIN`, 255: highest bin searched (inclusive); positive-frequency half only.
- `THRESH`, 1000: magnitude at or above which `note_on` is set.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `reset_max`  in  1  synchronous clear of the running search; held high by the sequencer while it listens.
- `bin_valid`  in  1  `bin_re`, `bin_im` and `bin_index` are valid this cycle.
- `bin_index`  in  IDX_W  bin number (the sequencer's `output_index`).
- `bin_re`, `bin_im`  in  DATA_W  signed two's-complement real and imaginary parts.
- `peak_valid`  out  1  one-cycle pulse; the result outputs were updated this cycle.
- `peak_bin`  out  IDX_W  winning bin of the last completed frame.
- `peak_mag`  out  2*DATA_W+1  unsigned magnitude of `peak_bin`.
- `note_on`  out  1  `peak_mag >= THRESH`, registered together with `peak_bin`.
- `busy`  out  1  high in ACCUM and FLUSH.

## Operation
- States:
  - IDLE: waits for `bin_valid` && `bin_index == 0`, then goes to ACCUM and processes that bin. Valid bins with any other index are ignored in IDLE.
  - ACCUM: processes each valid bin. On `bin_valid` && `bin_index == 2^IDX_W-1`, goes to FLUSH.
  - FLUSH: 3 cycles to drain the pipeline, then goes to REPORT.
  - REPORT: 1 cycle. Copies the running max into the result registers, pulses `peak_valid`, returns to IDLE.
- Gaps in `bin_valid` during ACCUM are legal. Each pipeline stage carries its own valid bit and no bins are counted. The frame ends only on the last index.
- `bin_valid` && `bin_index == 0` while in ACCUM restarts the frame: clears the running max and the pipeline, then accepts that bin.
- Pipeline:
  - S1 registers |re| and |im| as DATA_W+1-bit unsigned values, so -2^(DATA_W-1) maps to 2^(DATA_W-1).
  - S2 registers the magnitude, zero-extended to 2*DATA_W+1 bits; no overflow is possible.
  - S3 compares against the running max and updates.
- Update rule: the running max updates only when the bin is in `MIN_BIN..MAX_BIN` and its magnitude is strictly greater than the running max. On equal magnitudes the lower bin is kept.
- The running max starts each frame at 0 with bin 0. If no in-window bin is nonzero, the frame reports `peak_bin = 0`, `peak_mag = 0`, `note_on = 0`.
- `reset_max` high in any state:
  - clears the running max and all pipeline valid bits;
  - forces IDLE next cycle;
  - leaves `peak_bin`, `peak_mag` and `note_on` holding the previous frame's result, with no `peak_valid` pulse.
- `reset_max` has priority over a simultaneous `bin_valid`; that bin is dropped.

## Timing
- Reset values: state IDLE; `peak_valid` 0, `peak_bin` 0, `peak_mag` 0, `note_on` 0, `busy` 0; all pipeline valid bits 0.
- Result latency: `peak_valid` is high in the 4th cycle after the edge that samples the last bin (index 2^IDX_W-1).
- `busy` falls on the same edge that raises `peak_valid`.
- A new frame's index 0 is accepted as soon as REPORT has returned the block to IDLE. There is no input back-pressure, so the producer must not start a new frame earlier.
- Result outputs change only on the `peak_valid` edge.

## Configuration
- `PEAK_SQUARED_MAG_EN`:
  - Defined: S2 computes re² + im² (maximum 2^(2*DATA_W-1), fits in 2*DATA_W+1 bits), using one multiplier per component.
  - Undefined: S2 computes |re| + |im| (L1 approximation, no multipliers), zero-extended.
  - Latency, ports and widths are identical in both builds.

## Test plan
- Tone at bin 37 (re = 3000, im = -4000); all other bins 0; full 512-bin sweep -> `peak_valid` one cycle, 4 cycles after index 511; `peak_bin = 37`; `peak_mag = 7000` (L1) or 25000000 (squared); `note_on = 1`.
- Equal magnitudes of 500 at bins 10 and 20; all else 0 -> `peak_bin = 10`, `note_on = 0`.
- Bin 0 = 30000 and bin 300 = 30000 (both outside the window); bin 5 = 1 -> `peak_bin = 5`, `peak_mag = 1`.
- Bin 100 with re = -32768, im = 0 -> `peak_mag = 32768` (L1) or 1073741824 (squared); no sign error.
- Frame 1 completes with peak at bin 37; frame 2 in progress when `reset_max` pulses at index 200 -> no `peak_valid` pulse; outputs still show bin 37; block in IDLE; next frame starting at index 0 reports normally.
- `reset` asserted mid-ACCUM, asynchronously between edges -> all outputs 0 immediately and state IDLE.
- `bin_valid` deasserted for 3 cycles at random points during a sweep -> same result as the gap-free sweep.
